// File: rtl/arb_wrr_4_pkg.sv
// Shared types and helpers for the four-client weighted round-robin arbiter.
// Weight extraction and one-hot/index conversion live here so the bench can reuse them.
package arb_wrr_4_pkg;

    localparam int NCLI = 4;

    typedef logic [1:0]      cli_idx_t;
    typedef logic [NCLI-1:0] cli_vec_t;

    // Outcome of the per-cycle grant decision
    typedef enum logic [1:0] {
        DEC_IDLE = 2'd0,
        DEC_CONT = 2'd1,
        DEC_ROT  = 2'd2
    } grant_dec_e;

    typedef struct packed {
        logic     valid;
        cli_idx_t id;
    } rd_tag_t;

    function automatic logic [3:0] wgt_of(input logic [15:0] wgt, input cli_idx_t k);
        logic [3:0] w;
        w = wgt[{k, 2'b00} +: 4];
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    function automatic cli_vec_t idx_to_onehot(input cli_idx_t i);
        return cli_vec_t'(1) << i;
    endfunction

    function automatic cli_idx_t onehot_to_idx(input cli_vec_t v);
        cli_idx_t idx;
        idx = '0;
        for (int i = 0; i < NCLI; i++) begin
            if (v[i]) idx = cli_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_wrr_4_if.sv
// Client request/grant bus plus memory command/return bus of the arbiter.
// slave = arbiter side, master = clients and memory side.
interface arb_wrr_4_if #(
    parameter int W  = 16,
    parameter int AW = 10
);
    import arb_wrr_4_pkg::*;

    logic [NCLI-1:0]    client_req;
    logic [NCLI-1:0]    client_read;
    logic [NCLI*AW-1:0] client_addr;
    logic [NCLI*W-1:0]  client_wdata;
    logic [NCLI-1:0]    client_gnt;
    logic [NCLI-1:0]    client_rvalid;
    logic [W-1:0]       client_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [W-1:0]       mem_wdata;
    logic [W-1:0]       mem_rdata;

    modport slave (
        input  client_req, client_read, client_addr, client_wdata, mem_rdata,
        output client_gnt, client_rvalid, client_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output client_req, client_read, client_addr, client_wdata, mem_rdata,
        input  client_gnt, client_rvalid, client_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_wrr_4_rd_tag_pipe.sv
// Delay line carrying {valid, client id} of each granted read until its data returns.
// Cleared by reset so reads in flight at reset never produce a valid.
module rd_tag_pipe
    import arb_wrr_4_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t din,
    output rd_tag_t dout
);

    rd_tag_t stage [DEPTH];

    // NOTE: every stage is cleared, not just the valid bit, because stale ids must never reach the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/arb_wrr_4.sv
// Four-client weighted round-robin arbiter in front of a single-port memory.
// Grant and memory command are combinational from client_req; owner/credit update on clk.
module arb_wrr_4
    import arb_wrr_4_pkg::*;
#(
    parameter int          W      = 16,
    parameter int          AW     = 10,
    parameter logic [15:0] WGT    = 16'h1111,
    parameter int          RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    arb_wrr_4_if.slave  bus
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("arb_wrr_4: RD_LAT must be 1 to 4");
    end

    cli_idx_t   owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    cli_idx_t   rot_idx, gnt_idx, cand;
    logic       found, gnt_any;
    grant_dec_e dec;
    rd_tag_t    tag_in, tag_out;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        rot_idx = owner_q;
        found   = 1'b0;
        cand    = owner_q;
        // Search order owner+1 .. owner+3 then owner itself, so an exhausted sole requester is re-granted
        for (int off = 1; off <= NCLI; off++) begin
            cand = owner_q + cli_idx_t'(off);
            if (!found && bus.client_req[cand]) begin
                found   = 1'b1;
                rot_idx = cand;
            end
        end

        if (!rst_n || !found)
            dec = DEC_IDLE;
        else if (bus.client_req[owner_q] && (cnt_q < wgt_of(WGT, owner_q)))
            dec = DEC_CONT;
        else
            dec = DEC_ROT;

        gnt_idx = owner_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (dec)
            DEC_CONT: cnt_d = cnt_q + 4'd1;
            DEC_ROT: begin
                gnt_idx = rot_idx;
                owner_d = rot_idx;
                cnt_d   = 4'd1;
            end
            default: ;
        endcase
    end

    assign gnt_any = (dec != DEC_IDLE);

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.client_gnt = gnt_any ? idx_to_onehot(gnt_idx) : '0;
    assign bus.mem_en     = gnt_any;
    assign bus.mem_we     = gnt_any & ~bus.client_read[gnt_idx];
    assign bus.mem_addr   = gnt_any ? bus.client_addr[gnt_idx*AW +: AW] : '0;
    assign bus.mem_wdata  = gnt_any ? bus.client_wdata[gnt_idx*W +: W] : '0;

    always_comb begin
        tag_in.valid = gnt_any & bus.client_read[gnt_idx];
        tag_in.id    = gnt_idx;
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (tag_in),
        .dout (tag_out)
    );

    // Gated by rst_n so a read returning during the reset cycle is also dropped
    assign bus.client_rvalid = (rst_n && tag_out.valid) ? idx_to_onehot(tag_out.id) : '0;
    assign bus.client_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_arb_wrr_4.sv
// Bench for arb_wrr_4: two instances (plain weights/RD_LAT=2 and weighted/RD_LAT=1) share stimulus
// and are compared every cycle against a behavioural grant/readback model.
module tb_arb_wrr_4;
    import arb_wrr_4_pkg::*;

    localparam int          W     = 16;
    localparam int          AW    = 10;
    localparam logic [15:0] WGT_A = 16'h1111;
    localparam logic [15:0] WGT_B = 16'h1213;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      req = '0;
    logic [3:0]      rd = '0;
    logic [4*AW-1:0] addr = '0;
    logic [4*W-1:0]  wdata = '0;

    arb_wrr_4_if #(.W(W), .AW(AW)) if_a ();
    arb_wrr_4_if #(.W(W), .AW(AW)) if_b ();

    assign if_a.client_req   = req;
    assign if_a.client_read  = rd;
    assign if_a.client_addr  = addr;
    assign if_a.client_wdata = wdata;
    assign if_b.client_req   = req;
    assign if_b.client_read  = rd;
    assign if_b.client_addr  = addr;
    assign if_b.client_wdata = wdata;

    arb_wrr_4 #(.W(W), .AW(AW), .WGT(WGT_A), .RD_LAT(LAT_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    arb_wrr_4 #(.W(W), .AW(AW), .WGT(WGT_B), .RD_LAT(LAT_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    // Memory models: read data captured at the edge after the command, then delayed to RD_LAT
    logic [W-1:0] mem_a [1024];
    logic [W-1:0] mem_b [1024];
    logic [W-1:0] rp_a [4];
    logic [W-1:0] rp_b [4];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] <= W'(i * 37 + 11);
            mem_b[i] <= W'(i * 37 + 11);
        end
    end

    always @(posedge clk) begin
        if (if_a.mem_en) begin
            if (if_a.mem_we) mem_a[if_a.mem_addr] <= if_a.mem_wdata;
            else             rp_a[0] <= mem_a[if_a.mem_addr];
        end
        if (if_b.mem_en) begin
            if (if_b.mem_we) mem_b[if_b.mem_addr] <= if_b.mem_wdata;
            else             rp_b[0] <= mem_b[if_b.mem_addr];
        end
        for (int i = 1; i < 4; i++) begin
            rp_a[i] <= rp_a[i-1];
            rp_b[i] <= rp_b[i-1];
        end
    end

    assign if_a.mem_rdata = rp_a[LAT_A-1];
    assign if_b.mem_rdata = rp_b[LAT_B-1];

    // Reference model state
    int           m_owner [2];
    int           m_cnt   [2];
    logic [3:0]   exp_rv  [2][8];
    logic [W-1:0] exp_rd  [2][8];
    logic [W-1:0] ref_mem [2][1024];
    int           cyc;

    logic [3:0]   act_gnt [2];
    logic [3:0]   act_rv  [2];
    logic [W-1:0] act_rd  [2];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int wt(input int inst, input int k);
        int v;
        v = (((inst == 0) ? WGT_A : WGT_B) >> (4 * k)) % 16;
        return (v == 0) ? 1 : v;
    endfunction

    // One clock cycle: inputs are already applied; sample mid-cycle, compare, advance the model.
    task automatic tick();
        @(negedge clk);
        act_gnt[0] = if_a.client_gnt;    act_gnt[1] = if_b.client_gnt;
        act_rv[0]  = if_a.client_rvalid; act_rv[1]  = if_b.client_rvalid;
        act_rd[0]  = if_a.client_rdata;  act_rd[1]  = if_b.client_rdata;
        for (int i = 0; i < 2; i++) begin
            int k;
            bit cont;
            int lat;
            int slot;
            logic [3:0]    e_gnt;
            logic [3:0]    e_rv;
            logic [AW-1:0] e_addr;
            logic [W-1:0]  e_wd;
            logic          a_en, a_we;
            logic [AW-1:0] a_addr;
            logic [W-1:0]  a_wd;
            string sfx;
            sfx  = (i == 0) ? "a" : "b";
            lat  = (i == 0) ? LAT_A : LAT_B;
            k    = -1;
            cont = 1'b0;
            if (rst_n && req != 4'd0) begin
                if (req[m_owner[i]] && m_cnt[i] < wt(i, m_owner[i])) begin
                    k = m_owner[i];
                    cont = 1'b1;
                end else begin
                    for (int off = 1; off <= 4; off++) begin
                        if (req[(m_owner[i] + off) % 4]) begin
                            k = (m_owner[i] + off) % 4;
                            break;
                        end
                    end
                end
            end
            e_gnt  = (k < 0) ? 4'd0 : 4'(1 << k);
            e_addr = (k < 0) ? '0 : addr[k*AW +: AW];
            e_wd   = (k < 0) ? '0 : wdata[k*W +: W];
            slot   = cyc % 8;
            e_rv   = rst_n ? exp_rv[i][slot] : 4'd0;
            a_en   = (i == 0) ? if_a.mem_en    : if_b.mem_en;
            a_we   = (i == 0) ? if_a.mem_we    : if_b.mem_we;
            a_addr = (i == 0) ? if_a.mem_addr  : if_b.mem_addr;
            a_wd   = (i == 0) ? if_a.mem_wdata : if_b.mem_wdata;
            check({"gnt_", sfx}, 64'(act_gnt[i]), 64'(e_gnt));
            check({"mem_en_", sfx}, 64'(a_en), 64'(k >= 0));
            check({"mem_we_", sfx}, 64'(a_we), 64'(k >= 0 && !rd[k]));
            check({"mem_addr_", sfx}, 64'(a_addr), 64'(e_addr));
            check({"mem_wdata_", sfx}, 64'(a_wd), 64'(e_wd));
            check({"rvalid_", sfx}, 64'(act_rv[i]), 64'(e_rv));
            if (e_rv != 4'd0) check({"rdata_", sfx}, 64'(act_rd[i]), 64'(exp_rd[i][slot]));
            exp_rv[i][slot] = 4'd0;

            if (!rst_n) begin
                m_owner[i] = 0;
                m_cnt[i]   = 0;
                for (int s = 0; s < 8; s++) exp_rv[i][s] = 4'd0;
            end else if (k >= 0) begin
                if (cont) begin
                    m_cnt[i]++;
                end else begin
                    m_owner[i] = k;
                    m_cnt[i]   = 1;
                end
                if (rd[k]) begin
                    exp_rv[i][(cyc + lat) % 8] = 4'(1 << k);
                    exp_rd[i][(cyc + lat) % 8] = ref_mem[i][e_addr];
                end else begin
                    ref_mem[i][e_addr] = e_wd;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt_a;
        logic [3:0] gnt_b;
    } vec_t;

    vec_t tbl [25];

    initial begin
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 0;
            m_cnt[i]   = 0;
            for (int s = 0; s < 8; s++) begin
                exp_rv[i][s] = 4'd0;
                exp_rd[i][s] = '0;
            end
            for (int a = 0; a < 1024; a++) ref_mem[i][a] = W'(a * 37 + 11);
        end

        // Reset with all requesting, then free-running round robin, then client 2 alone
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 4'hF, 4'h0, 4'h0};
        tbl[5]  = '{1'b1, 4'hF, 4'h1, 4'h1};
        tbl[6]  = '{1'b1, 4'hF, 4'h2, 4'h1};
        tbl[7]  = '{1'b1, 4'hF, 4'h4, 4'h1};
        tbl[8]  = '{1'b1, 4'hF, 4'h8, 4'h2};
        tbl[9]  = '{1'b1, 4'hF, 4'h1, 4'h4};
        tbl[10] = '{1'b1, 4'hF, 4'h2, 4'h4};
        tbl[11] = '{1'b1, 4'hF, 4'h4, 4'h8};
        tbl[12] = '{1'b1, 4'hF, 4'h8, 4'h1};
        tbl[13] = '{1'b1, 4'hF, 4'h1, 4'h1};
        tbl[14] = '{1'b1, 4'hF, 4'h2, 4'h1};
        tbl[15] = '{1'b1, 4'hF, 4'h4, 4'h2};
        tbl[16] = '{1'b1, 4'hF, 4'h8, 4'h4};
        tbl[17] = '{1'b1, 4'hF, 4'h1, 4'h4};
        tbl[18] = '{1'b1, 4'hF, 4'h2, 4'h8};
        for (int i = 19; i < 25; i++) tbl[i] = '{1'b1, 4'h4, 4'h4, 4'h4};

        @(posedge clk);
        #1;
        rd = 4'h0;
        for (int i = 0; i < 4; i++) begin
            addr[i*AW +: AW] = AW'(100 + i);
            wdata[i*W +: W]  = W'(16'h1000 + i);
        end
        for (int i = 0; i < 25; i++) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            tick();
            check("tbl_gnt_a", 64'(act_gnt[0]), 64'(tbl[i].gnt_a));
            check("tbl_gnt_b", 64'(act_gnt[1]), 64'(tbl[i].gnt_b));
            if (!tbl[i].rst_n) begin
                check("tbl_rst_rv_a", 64'(act_rv[0]), 64'd0);
                check("tbl_rst_rv_b", 64'(act_rv[1]), 64'd0);
            end
        end
        check("sole_owner_a", 64'(dut_a.owner_q), 64'd2);
        check("sole_cnt_a", 64'(dut_a.cnt_q), 64'd1);

        // Read routing: preload 5/6 via client0, then client1 reads 5 and client3 reads 6
        req = 4'h1; rd = 4'h0; addr[0 +: AW] = AW'(5); wdata[0 +: W] = 16'hA5A5;
        tick();
        addr[0 +: AW] = AW'(6); wdata[0 +: W] = 16'h5A5A;
        tick();
        req = 4'h2; rd = 4'h2; addr[1*AW +: AW] = AW'(5);
        tick();
        check("rd_gnt1_a", 64'(act_gnt[0]), 64'h2);
        req = 4'h8; rd = 4'h8; addr[3*AW +: AW] = AW'(6);
        tick();
        check("rd_gnt3_a", 64'(act_gnt[0]), 64'h8);
        check("rd_early_rv_a", 64'(act_rv[0]), 64'h0);
        req = 4'h0; rd = 4'h0;
        tick();
        check("rd_rv1_a", 64'(act_rv[0]), 64'h2);
        check("rd_data1_a", 64'(act_rd[0]), 64'hA5A5);
        tick();
        check("rd_rv3_a", 64'(act_rv[0]), 64'h8);
        check("rd_data3_a", 64'(act_rd[0]), 64'h5A5A);
        tick();
        check("rd_quiet_a", 64'(act_rv[0]), 64'h0);

        // Reset while a read is in flight: nothing may return
        req = 4'h1; rd = 4'h1; addr[0 +: AW] = AW'(5);
        tick();
        check("mid_gnt_a", 64'(act_gnt[0]), 64'h1);
        rst_n = 1'b0; req = 4'h0; rd = 4'h0;
        tick();
        check("mid_rst_rv_a", 64'(act_rv[0]), 64'h0);
        check("mid_rst_rv_b", 64'(act_rv[1]), 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_post_rv_a", 64'(act_rv[0]), 64'h0);
            check("mid_post_rv_b", 64'(act_rv[1]), 64'h0);
        end
        check("mid_owner_a", 64'(dut_a.owner_q), 64'd0);
        check("mid_cnt_a", 64'(dut_a.cnt_q), 64'd0);
        check("mid_owner_b", 64'(dut_b.owner_q), 64'd0);
        check("mid_cnt_b", 64'(dut_b.cnt_q), 64'd0);

        // Random traffic against the model, with occasional reset
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req   = 4'($urandom);
            rd    = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                wdata[i*W +: W]  = W'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_wrr_4.md
# arb_wrr_4

Four-client weighted round-robin arbiter that shares one single-port data memory between streaming clients such as `setmi` instances. Each client drives a memory request (read or write, address, write data). The arbiter grants one client per cycle, forwards that client's command to the memory, and routes read data back with a per-client valid. Per-client weights set how many consecutive grants a client may hold before ownership rotates.

## Interface

Parameters:
- `W`, 16, data width.
- `AW`, 10, address width.
- `WGT`, 16'h1111, four 4-bit weights; client k weight = `WGT[4k+3:4k]`; a weight of 0 is treated as 1.
- `RD_LAT`, 1, memory read latency in cycles; must be 1 to 4.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `client_req`  in  4  request per client.
- `client_read`  in  4  1 = read, 0 = write; qualified by `client_req`.
- `client_addr`  in  4*AW  client k address at `[k*AW +: AW]`.
- `client_wdata`  in  4*W  client k write data at `[k*W +: W]`.
- `client_gnt`  out  4  one-hot grant, same cycle as the request.
- `client_rvalid`  out  4  read data valid for client k.
- `client_rdata`  out  W  read data, shared by all clients.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  W  memory write data.
- `mem_rdata`  in  W  memory read data, valid RD_LAT cycles after `mem_en & ~mem_we`.

## Operation

State:
- `owner`: 2 bits, reset 0.
- `cnt`: 4 bits, grants given in the current turn, reset 0.
- Read tag pipe: RD_LAT stages of {valid, id}, reset all invalid.

Per-cycle grant decision, combinational from `client_req` and state:
- **Continue:** if `client_req[owner]` and `cnt < wgt(owner)`, grant `owner`. Next `cnt = cnt+1`.
- **Rotate:** otherwise search `owner+1, owner+2, owner+3, owner` mod 4 and grant the first requester k. Next `owner = k`, `cnt = 1`.
- **Idle:** if no requester, no grant; `owner` and `cnt` are unchanged.
- An exhausted owner that is the only requester is re-granted with `cnt = 1`. It never starves.

Memory command:
- `mem_en = |client_gnt`.
- `mem_we`, `mem_addr`, `mem_wdata` are muxed from the granted client.
- When `mem_en = 0`, these are all 0.

Read path:
- A granted read pushes {1, id} into the tag pipe.
- The pipe output asserts `client_rvalid[id]` exactly RD_LAT cycles later.
- `client_rdata = mem_rdata` at all times.

Handshake:
- A request with `client_gnt` high in that cycle is accepted.
- A client holds `client_req` and its command stable until granted.
- Deasserting `client_req` before grant withdraws the request.

Reset (while `rst_n` is low):
- `client_gnt`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` and `client_rvalid` are all 0 regardless of inputs.
- Asserting reset mid-operation flushes the tag pipe. Reads in flight never return a valid.

## Timing

- Grant and memory command are combinational from `client_req` in the same cycle.
- State updates on the `clk` edge.
- Read data valid arrives RD_LAT cycles after the grant cycle.
- Throughput: one access per cycle. Back-to-back reads from different clients return in grant order, one per cycle.
- No combinational path from `mem_rdata` to any grant.

## Structure

- Shared package holds:
  - `NCLI = 4`;
  - the weight-extract function (field k, 0 mapped to 1);
  - the one-hot/index conversion functions.
- One sub-module, `rd_tag_pipe`: parameterized depth RD_LAT, width 1+2, synchronous active-low clear.
- Top level contains the grant search, owner/credit registers and command mux.

## Test plan

- **Reset:** hold `rst_n=0` for 5 cycles with `client_req=4'hF` -> `client_gnt=0`, `mem_en=0`, `client_rvalid=0`. First cycle after release -> `client_gnt=4'b0001`.
- **Plain round-robin:** `WGT=16'h1111`, `client_req=4'hF` held -> grants cycle 0001, 0010, 0100, 1000, 0001, …
- **Weighted rotation:** `WGT=16'h1213`, `client_req=4'hF` held -> client0 granted 3 cycles, client1 1, client2 2, client3 1; pattern repeats every 7 cycles.
- **Sole requester re-grant:** `WGT=16'h1111`, only `client_req[2]` high for 6 cycles -> granted every cycle; `owner` stays 2, `cnt` stays 1.
- **Read routing:** `RD_LAT=2`. Client1 reads address 5 (mem[5]=16'hA5A5), then the next cycle client3 reads address 6 (mem[6]=16'h5A5A) -> `client_rvalid[1]` 2 cycles after its grant with rdata 16'hA5A5, `client_rvalid[3]` the following cycle with rdata 16'h5A5A.
- **Reset mid-read:** grant a read, assert `rst_n=0` the next cycle -> no `client_rvalid` pulse afterwards; after release, `owner=0`, `cnt=0`.
